ecc_secded_codec: RTL and testbench

//  Parametrised, pipelined Hamming SECDED codec. Per beat, encodes DATA_W data bits into a CW-bit codeword, or checks, corrects and scrubs a received codeword.

---
 rtl/ecc_secded_codec.sv | 164 ++++++++++++++++
 tb/tb_ecc_secded_codec.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_secded_codec.sv
// Pipelined Hamming SECDED encoder/decoder with scrub correction.
// Two register stages, valid/ready flow control, saturating CE/UE counters.
module ecc_secded_codec #(
  parameter int DATA_W = 64,
  parameter int COUNT_W = 16,
  localparam int R =
    $clog2(DATA_W + 1 + $clog2(DATA_W + 1 + $clog2(DATA_W + 1))),
  localparam int CHECK_W = R + 1,
  localparam int CW = DATA_W + CHECK_W
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [CW-1:0]      in_word,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CW-1:0]      out_word,
  output logic [CHECK_W-1:0] out_syndrome,
  output logic               out_ce,
  output logic               out_ue,
  input  logic               clr_counts,
  output logic [COUNT_W-1:0] ce_count,
  output logic [COUNT_W-1:0] ue_count
);

  function automatic int dpos(input int j);
    int c;
    int p;
    c = 0;
    p = 0;
    for (int q = 1; q <= DATA_W + R; q++) begin
      if ((q & (q - 1)) != 0) begin
        if (c == j) p = q;
        c++;
      end
    end
    return p;
  endfunction

  localparam logic [R-1:0] NPOS = R'(DATA_W + R);

  // Hamming position of each data bit, resolved at elaboration
  logic [R-1:0] w_pos [DATA_W];
  for (genvar j = 0; j < DATA_W; j++) begin : g_pos
    localparam int P = dpos(j);
    assign w_pos[j] = R'(P);
  end

  logic [DATA_W-1:0] w_din;
  logic [R-1:0]      w_ham;
  logic [CW-1:0]     w_enc;
  logic [R-1:0]      w_syn;
  logic              w_par;

  assign w_din = in_word[DATA_W-1:0];

  always_comb begin
    w_ham = '0;
    for (int j = 0; j < DATA_W; j++) begin
      for (int i = 0; i < R; i++) begin
        if (w_pos[j][i]) w_ham[i] = w_ham[i] ^ w_din[j];
      end
    end
  end

  assign w_enc = {(^w_din) ^ (^w_ham), w_ham, w_din};
  assign w_syn = w_ham ^ in_word[DATA_W +: R];
  assign w_par = ^in_word;

  logic          r_v1;
  logic          r_mode1;
  logic [CW-1:0] r_word1;
  logic [R-1:0]  r_syn1;
  logic          r_par1;

  logic w_s2_rdy;
  logic w_adv1;
  logic w_acc;
  logic w_hs;

  assign w_s2_rdy = ~out_valid | out_ready;
  assign w_adv1   = r_v1 & w_s2_rdy;
  assign in_ready = ~r_v1 | w_adv1;
  assign w_acc    = in_valid & in_ready;
  assign w_hs     = out_valid & out_ready;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_v1    <= 1'b0;
      r_mode1 <= 1'b0;
      r_word1 <= '0;
      r_syn1  <= '0;
      r_par1  <= 1'b0;
    end else begin
      if (w_acc) begin
        r_v1    <= 1'b1;
        r_mode1 <= in_mode;
        r_word1 <= in_mode ? in_word : w_enc;
        r_syn1  <= w_syn;
        r_par1  <= w_par;
      end else if (w_adv1) begin
        r_v1 <= 1'b0;
      end
    end
  end

  logic [CW-1:0] w_flip;
  logic          w_fix;
  logic          w_ue1;
  logic [CW-1:0] w_corr;

  assign w_fix = r_par1 & (r_syn1 <= NPOS);
  assign w_ue1 = r_par1 ? (r_syn1 > NPOS) : (r_syn1 != '0);

  // One-hot flip mask; syndrome 0 with odd parity means check[R] itself
  always_comb begin
    w_flip = '0;
    for (int j = 0; j < DATA_W; j++) begin
      w_flip[j] = (w_pos[j] == r_syn1);
    end
    for (int i = 0; i < R; i++) begin
      w_flip[DATA_W+i] = (r_syn1 == (R'(1) << i));
    end
    w_flip[CW-1] = (r_syn1 == '0);
  end

  assign w_corr = w_fix ? (r_word1 ^ w_flip) : r_word1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out_valid    <= 1'b0;
      out_word     <= '0;
      out_syndrome <= '0;
      out_ce       <= 1'b0;
      out_ue       <= 1'b0;
    end else begin
      if (w_adv1) begin
        out_valid    <= 1'b1;
        out_word     <= r_mode1 ? w_corr : r_word1;
        out_syndrome <= r_mode1 ? {r_par1, r_syn1} : '0;
        out_ce       <= r_mode1 & w_fix;
        out_ue       <= r_mode1 & w_ue1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ce_count <= '0;
      ue_count <= '0;
    end else if (clr_counts) begin
      ce_count <= '0;
      ue_count <= '0;
    end else if (w_hs) begin
      if (out_ce && !(&ce_count)) ce_count <= ce_count + 1'b1;
      if (out_ue && !(&ue_count)) ue_count <= ue_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ecc_secded_codec.sv
// Randomised scoreboard bench for ecc_secded_codec (DATA_W=64, COUNT_W=4).
// Reference model works on an explicit Hamming position array.
module tb_ecc_secded_codec;

  localparam int DW = 64;
  localparam int R = 7;
  localparam int CHK = 8;
  localparam int CW = 72;
  localparam int NP = 71;
  localparam int CNTW = 4;
  localparam int CMAX = 15;

  logic            sys_clk = 1'b0;
  logic            sys_rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_mode = 1'b0;
  logic [CW-1:0]   in_word = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [CW-1:0]   out_word;
  logic [CHK-1:0]  out_syndrome;
  logic            out_ce;
  logic            out_ue;
  logic            clr_counts = 1'b0;
  logic [CNTW-1:0] ce_count;
  logic [CNTW-1:0] ue_count;

  ecc_secded_codec #(.DATA_W(DW), .COUNT_W(CNTW)) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_mode(in_mode),
    .in_word(in_word),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_word(out_word),
    .out_syndrome(out_syndrome),
    .out_ce(out_ce),
    .out_ue(out_ue),
    .clr_counts(clr_counts),
    .ce_count(ce_count),
    .ue_count(ue_count)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [CW-1:0]  w;
    logic [CHK-1:0] s;
    logic           ce;
    logic           ue;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_tot = 0;
  int   m_ce = 0;
  int   m_ue = 0;
  bit   rnd_rdy = 1'b0;
  bit   exp_full = 1'b0;

  task automatic chk(input string nm, input logic [CW-1:0] act,
                     input logic [CW-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic bit is_p2(input int v);
    return (v & (v - 1)) == 0;
  endfunction

  function automatic logic [CW-1:0] m_encode(input logic [DW-1:0] d);
    logic [NP:0]  c;
    logic [R-1:0] k;
    int n;
    c = '0;
    n = 0;
    for (int p = 1; p <= NP; p++) begin
      if (!is_p2(p)) begin
        c[p] = d[n];
        n++;
      end
    end
    k = '0;
    for (int i = 0; i < R; i++) begin
      for (int p = 1; p <= NP; p++) begin
        if (((p >> i) & 1) == 1) k[i] = k[i] ^ c[p];
      end
    end
    return {(^d) ^ (^k), k, d};
  endfunction

  function automatic exp_t m_model(input logic mode, input logic [CW-1:0] w);
    exp_t e;
    logic [NP:0] c;
    int syn;
    int n;
    logic p;
    e = '0;
    if (!mode) begin
      e.w = m_encode(w[DW-1:0]);
      return e;
    end
    c = '0;
    n = 0;
    for (int b = 1; b <= NP; b++) begin
      if (is_p2(b)) c[b] = w[DW + $clog2(b)];
      else begin
        c[b] = w[n];
        n++;
      end
    end
    syn = 0;
    for (int b = 1; b <= NP; b++) if (c[b]) syn = syn ^ b;
    p = ^w;
    e.s = {p, 7'(syn)};
    e.w = w;
    if (p && syn == 0) begin
      e.ce = 1'b1;
      e.w[CW-1] = ~w[CW-1];
    end else if (p && syn <= NP) begin
      e.ce = 1'b1;
      c[syn] = ~c[syn];
      n = 0;
      for (int b = 1; b <= NP; b++) begin
        if (is_p2(b)) e.w[DW + $clog2(b)] = c[b];
        else begin
          e.w[n] = c[b];
          n++;
        end
      end
    end else if (syn != 0) begin
      e.ue = 1'b1;
    end
    return e;
  endfunction

  always @(posedge sys_clk) begin
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    else out_ready = 1'b1;
  end

  exp_t prev;
  bit   prev_stall = 1'b0;

  always @(negedge sys_clk) begin
    exp_t e;
    if (!sys_rst_n) begin
      prev_stall = 1'b0;
      m_ce = 0;
      m_ue = 0;
    end else begin
      chk("ce_count", CW'(ce_count), CW'(m_ce));
      chk("ue_count", CW'(ue_count), CW'(m_ue));
      if (out_valid) chk("ce_ue_excl", CW'(out_ce & out_ue), '0);
      if (prev_stall) begin
        chk("stall_valid", CW'(out_valid), CW'(1));
        chk("stall_word", out_word, prev.w);
        chk("stall_flags", CW'({out_syndrome, out_ce, out_ue}),
            CW'({prev.s, prev.ce, prev.ue}));
      end
      prev_stall = out_valid & ~out_ready;
      prev = {out_word, out_syndrome, out_ce, out_ue};
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", CW'(1), '0);
        end else begin
          e = q.pop_front();
          chk("out_word", out_word, e.w);
          chk("out_syndrome", CW'(out_syndrome), CW'(e.s));
          chk("out_flags", CW'({out_ce, out_ue}), CW'({e.ce, e.ue}));
          if (!clr_counts) begin
            if (e.ce && m_ce < CMAX) m_ce++;
            if (e.ue && m_ue < CMAX) m_ue++;
          end
        end
      end
      if (clr_counts) begin
        m_ce = 0;
        m_ue = 0;
      end
    end
  end

  task automatic send(input logic m, input logic [CW-1:0] w);
    int t;
    in_valid = 1'b1;
    in_mode = m;
    in_word = w;
    t = 0;
    @(negedge sys_clk);
    if (exp_full) chk("full_rate", CW'(in_ready), CW'(1));
    while (!in_ready && t < 200) begin
      @(negedge sys_clk);
      t++;
    end
    if (!in_ready) chk("accept_timeout", '0, CW'(1));
    else q.push_back(m_model(m, w));
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    in_valid = 1'b0;
    t = 0;
    while ((q.size() != 0 || out_valid) && t < 500) begin
      @(negedge sys_clk);
      t++;
    end
    if (t >= 500) chk("drain_timeout", '0, CW'(1));
    repeat (2) @(posedge sys_clk);
    #1;
  endtask

  task automatic direct(input string nm, input logic m, input logic [CW-1:0] w,
                        input logic [CW-1:0] ew, input logic [CHK-1:0] es,
                        input logic ece, input logic eue, input bit clr);
    in_valid = 1'b1;
    in_mode = m;
    in_word = w;
    @(negedge sys_clk);
    chk({nm, "_accept"}, CW'(in_ready), CW'(1));
    q.push_back(m_model(m, w));
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
    @(negedge sys_clk);
    chk({nm, "_lat1"}, CW'(out_valid), '0);
    @(posedge sys_clk);
    #1;
    if (clr) clr_counts = 1'b1;
    @(negedge sys_clk);
    chk({nm, "_lat2"}, CW'(out_valid), CW'(1));
    chk({nm, "_word"}, out_word, ew);
    chk({nm, "_syn"}, CW'(out_syndrome), CW'(es));
    chk({nm, "_flags"}, CW'({out_ce, out_ue}), CW'({ece, eue}));
    @(posedge sys_clk);
    #1;
    clr_counts = 1'b0;
    @(negedge sys_clk);
    if (clr) chk({nm, "_clr"}, CW'({ce_count, ue_count}), '0);
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [DW-1:0] d;
    logic [CW-1:0] w;
    logic m;
    int b0;
    int b1;

    e = m_model(1'b0, 72'h1);
    chk("pin_enc", e.w, 72'h83_0000000000000001);
    e = m_model(1'b1, 72'h1);
    chk("pin_dec1_word", e.w, '0);
    chk("pin_dec1_syn", CW'({e.s, e.ce, e.ue}), CW'({8'h83, 1'b1, 1'b0}));
    e = m_model(1'b1, 72'h3);
    chk("pin_dec2", CW'({e.s, e.ce, e.ue}), CW'({8'h06, 1'b0, 1'b1}));

    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_out_valid", CW'(out_valid), '0);
    chk("rst_out_word", out_word, '0);
    chk("rst_out_syn", CW'({out_syndrome, out_ce, out_ue}), '0);
    chk("rst_counts", CW'({ce_count, ue_count}), '0);
    chk("rst_in_ready", CW'(in_ready), CW'(1));
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    direct("t1", 1'b0, 72'h1, 72'h83_0000000000000001, 8'h00, 1'b0, 1'b0, 1'b0);
    direct("t2", 1'b1, 72'h1, 72'h0, 8'h83, 1'b1, 1'b0, 1'b0);
    direct("t3", 1'b1, 72'h3, 72'h3, 8'h06, 1'b0, 1'b1, 1'b0);

    rnd_rdy = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge sys_clk);
        #1;
      end
      m = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom};
      if (m) begin
        w = m_encode(d);
        b0 = $urandom_range(0, CW - 1);
        b1 = (b0 + $urandom_range(1, CW - 1)) % CW;
        case ($urandom_range(0, 3))
          0: ;
          1: w[b0] = ~w[b0];
          2: begin
            w[b0] = ~w[b0];
            w[b1] = ~w[b1];
          end
          default: w = {8'($urandom), d};
        endcase
      end else begin
        w = {8'($urandom), d};
      end
      send(m, w);
    end
    rnd_rdy = 1'b0;
    drain();

    exp_full = 1'b1;
    for (int n = 0; n < 20; n++) begin
      m = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom};
      w = m_encode(d);
      w[$urandom_range(0, CW - 1)] ^= 1'b1;
      send(m, w);
    end
    exp_full = 1'b0;
    drain();

    clr_counts = 1'b1;
    @(posedge sys_clk);
    #1;
    clr_counts = 1'b0;
    for (int n = 0; n < 20; n++) begin
      d = {$urandom, $urandom};
      w = m_encode(d);
      w[$urandom_range(0, CW - 1)] ^= 1'b1;
      send(1'b1, w);
    end
    drain();
    chk("ce_saturate", CW'(ce_count), CW'(4'hF));
    direct("t5clr", 1'b1, 72'h1, 72'h0, 8'h83, 1'b1, 1'b0, 1'b1);

    send(1'b0, {8'h0, $urandom, $urandom});
    send(1'b1, m_encode({$urandom, $urandom}) ^ 72'h10);
    #1;
    sys_rst_n = 1'b0;
    #1;
    chk("t6_out_valid", CW'(out_valid), '0);
    chk("t6_counts", CW'({ce_count, ue_count}), '0);
    q.delete();
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    #1;
    chk("t6_in_ready", CW'(in_ready), CW'(1));
    @(posedge sys_clk);
    #1;
    direct("t6post", 1'b0, 72'h1, 72'h83_0000000000000001, 8'h00, 1'b0, 1'b0, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
